// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : Central stall/flush sequencer for the 5-stage pipeline. Turns the
//            ID hazard flag, EX branch redirect, ID jump/halt decode and data
//            memory busy into stage write enables, bubbles and flushes. Owns
//            the halt-drain sequence and a sticky hazard-stall watchdog.
// Ports    : clk, rst (async, active high)
//            hazard, br_taken, jmp_id, halt_id, mem_busy   -- event inputs
//            pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
//            exmem_we, memwb_we                            -- stage controls
//            halted, stall_timeout, state_o[2:0]           -- status/debug
//            haz_cycles, mem_cycles, flush_count [CNT_W]   -- perf counters
// Option   : PIPE_STALL_PERF_CNT_EN adds the CNT_W-bit saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
  parameter int MAX_HAZ_STALL = 4,
  parameter int DRAIN_CYCLES  = 3
`ifdef PIPE_STALL_PERF_CNT_EN
  ,
  parameter int CNT_W         = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hazard,
  input  logic       br_taken,
  input  logic       jmp_id,
  input  logic       halt_id,
  input  logic       mem_busy,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_we,
  output logic       idex_bubble,
  output logic       exmem_we,
  output logic       memwb_we,
  output logic       halted,
  output logic       stall_timeout,
  output logic [2:0] state_o
`ifdef PIPE_STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] haz_cycles,
  output logic [CNT_W-1:0] mem_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int HW = $clog2(MAX_HAZ_STALL + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [HW-1:0] c_haz_max    = HW'(MAX_HAZ_STALL);
  localparam logic [DW-1:0] c_drain_last = DW'(DRAIN_CYCLES);

  localparam logic [2:0] c_st_run   = 3'd0;
  localparam logic [2:0] c_st_haz   = 3'd1;
  localparam logic [2:0] c_st_memw  = 3'd2;
  localparam logic [2:0] c_st_drain = 3'd3;
  localparam logic [2:0] c_st_halt  = 3'd4;

  // Per-cycle action chosen by the priority decode; both the output and the
  // next-state processes key off this so they can never disagree.
  localparam logic [2:0] c_act_none = 3'd0;
  localparam logic [2:0] c_act_frz  = 3'd1;
  localparam logic [2:0] c_act_br   = 3'd2;
  localparam logic [2:0] c_act_haz  = 3'd3;
  localparam logic [2:0] c_act_jmp  = 3'd4;
  localparam logic [2:0] c_act_halt = 3'd5;
  localparam logic [2:0] c_act_drn  = 3'd6;
  localparam logic [2:0] c_act_stop = 3'd7;

  logic [2:0]    r_state, w_state_nxt, w_act;
  logic [HW-1:0] r_haz_cnt, w_haz_cnt_nxt;
  logic [DW-1:0] r_drain_cnt, w_drain_cnt_nxt;
  logic          r_timeout, w_timeout_nxt;

  // Action decode
  always_comb begin
    w_act = c_act_none;
    case (r_state)
      c_st_halt: w_act = c_act_stop;
      c_st_drain: begin
        if (mem_busy)      w_act = c_act_frz;
        else if (br_taken) w_act = c_act_br;   // older branch squashes the halt
        else               w_act = c_act_drn;
      end
      default: begin                           // RUN, HAZ, MEMW
        if (mem_busy)      w_act = c_act_frz;
        else if (br_taken) w_act = c_act_br;
        else if (hazard)   w_act = c_act_haz;
        else if (jmp_id)   w_act = c_act_jmp;
        else if (halt_id)  w_act = c_act_halt;
        else               w_act = c_act_none;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_st_run;
      r_haz_cnt   <= '0;
      r_drain_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_haz_cnt   <= w_haz_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_haz_cnt_nxt   = r_haz_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    w_timeout_nxt   = r_timeout;
    case (w_act)
      c_act_frz: begin
        // A freeze during drain must not lose the halt sequence.
        w_state_nxt = (r_state == c_st_drain) ? c_st_drain : c_st_memw;
      end
      c_act_br: begin
        w_state_nxt     = c_st_run;
        w_haz_cnt_nxt   = '0;
        w_drain_cnt_nxt = '0;
      end
      c_act_haz: begin
        w_state_nxt = c_st_haz;
        if (r_haz_cnt != c_haz_max) w_haz_cnt_nxt = r_haz_cnt + HW'(1);
        if (r_state == c_st_haz && r_haz_cnt == c_haz_max) w_timeout_nxt = 1'b1;
      end
      c_act_jmp: w_state_nxt = c_st_run;
      c_act_halt: begin
        w_state_nxt     = c_st_drain;
        w_drain_cnt_nxt = DW'(1);
      end
      c_act_drn: begin
        if (r_drain_cnt == c_drain_last) w_state_nxt = c_st_halt;
        else                             w_drain_cnt_nxt = r_drain_cnt + DW'(1);
      end
      c_act_none: begin
        w_state_nxt   = c_st_run;
        w_haz_cnt_nxt = '0;
      end
      default: ;                               // HALT: wait for reset
    endcase
  end

  // Output logic; stage controls are forced low while reset is held.
  always_comb begin
    pc_we         = 1'b0;
    ifid_we       = 1'b0;
    ifid_flush    = 1'b0;
    idex_we       = 1'b0;
    idex_bubble   = 1'b0;
    exmem_we      = 1'b0;
    memwb_we      = 1'b0;
    halted        = (r_state == c_st_halt);
    stall_timeout = r_timeout;
    state_o       = r_state;
    if (!rst) begin
      case (w_act)
        c_act_none, c_act_jmp, c_act_br: begin
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          idex_we     = 1'b1;
          exmem_we    = 1'b1;
          memwb_we    = 1'b1;
          ifid_flush  = (w_act != c_act_none);
          idex_bubble = (w_act == c_act_br);
        end
        c_act_haz, c_act_halt, c_act_drn: begin
          // Hold PC and IF/ID, push a noop into ID/EX, let older stages retire.
          idex_we     = 1'b1;
          idex_bubble = 1'b1;
          exmem_we    = 1'b1;
          memwb_we    = 1'b1;
        end
        default: ;                             // freeze or halted
      endcase
    end
  end

`ifdef PIPE_STALL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] r_haz_cycles, r_mem_cycles, r_flush_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_haz_cycles  <= '0;
      r_mem_cycles  <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_act == c_act_haz && r_haz_cycles != c_cnt_max)
        r_haz_cycles <= r_haz_cycles + CNT_W'(1);
      if (w_act == c_act_frz && r_mem_cycles != c_cnt_max)
        r_mem_cycles <= r_mem_cycles + CNT_W'(1);
      if ((w_act == c_act_br || w_act == c_act_jmp) && r_flush_count != c_cnt_max)
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign haz_cycles  = r_haz_cycles;
  assign mem_cycles  = r_mem_cycles;
  assign flush_count = r_flush_count;
`endif

endmodule
`default_nettype wire
